instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart to the single-cycle RISC-V controller/decoder.
- Accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I words.
- Supports LW, SW, R-type ALU and BEQ-class B-type words, the set the controller decodes.
- Writes the words sequentially into instruction memory; serves as the program loader used for bring-up and test.

Parameters:
- IMEM_DEPTH, 64: number of 32-bit words in instruction memory.
- ADDR_W, $clog2(IMEM_DEPTH): word-address width, derived, not overridden.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_arst_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  begin a load session; address counter cleared to 0.
- i_valid  in  1  field bundle valid.
- o_ready  out  1  encoder can accept a bundle.
- i_opClass  in  2  instruction class: LW, SW, R_TYPE_ALU, B_TYPE.
- i_rd, i_rs1, i_rs2  in  5 each  register indices.
- i_funct3  in  3  funct3 field.
- i_funct7bit5  in  1  R-type bit 30, selects SUB/SRA.
- i_imm  in  13  signed byte offset.
- i_last  in  1  final bundle of the program.
- o_imemWriteEn  out  1  instruction memory write strobe.
- o_imemAddr  out  ADDR_W  word address.
- o_imemWriteData  out  32  encoded instruction.
- o_busy  out  1  session active.
- o_done  out  1  session completed.
- o_error  out  1  sticky error.

Behaviour:
- Reset: all outputs 0, state IDLE, address counter 0.
- FSM IDLE -> LOAD on i_start.
- LOAD -> DONE after a handshake with i_last=1, or when the counter reaches IMEM_DEPTH.
- LOAD -> ERR on an illegal bundle.
- DONE or ERR -> LOAD on i_start, which clears the counter, o_done and o_error.
- i_start while in LOAD restarts the session at address 0.
- o_ready = (state==LOAD) && !(pipeline write pending at address IMEM_DEPTH-1).
- Handshake: a bundle is accepted when i_valid && o_ready at a rising edge.
- Latency: exactly 1 cycle. The accepted bundle drives o_imemWriteEn=1, o_imemAddr, o_imemWriteData for one cycle, then the counter increments.
- Back-to-back bundles give a write every cycle.
- Encoding:
  - LW: {imm[11:0],rs1,3'b010,rd,7'b0000011}.
  - SW: {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}.
  - R_TYPE_ALU: {1'b0,funct7bit5,5'b0,rs2,rs1,funct3,rd,7'b0110011}.
  - B_TYPE: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],7'b1100011}.
- Illegal bundles:
  - LW/SW with imm outside [-2048, 2047], i.e. imm[12]!=imm[11].
  - B_TYPE with imm[0]=1.
  - Response: the word is not written, o_error=1, state ERR, o_ready=0.
- Full: the write to address IMEM_DEPTH-1 sets o_done the following cycle, even without i_last.
- o_busy = (state==LOAD) || write pending.
- o_done asserts the cycle after the last write and holds until i_start.
- Asynchronous reset mid-session aborts the session; any pending write strobe is dropped immediately.

Optional Feature:
- Macro INSTR_ENCODER_CHECKSUM_EN.
- Defined: output port o_checksum [31:0], the XOR of all words written this session. Cleared by reset and by i_start; valid when o_done=1.
- Undefined: the port and its logic are absent.

Decomposition:
- pa_riscv gains:
  - opClass enum (LW, SW, R_TYPE_ALU, B_TYPE).
  - 7-bit opcode constants.
  - FUNCT3_LW_SW = 3'b010.
  - FSM state enum (IDLE, LOAD, DONE, ERR).
- One combinational sub-module, instr_word_pack: fields -> 32-bit word plus illegal flag.
- The parent instr_encoder holds the FSM, counter, output register and checksum.

Test Plan:
- Start, LW rd=5 rs1=2 imm=8 -> write addr 0, data 0x00812283 one cycle after the handshake.
- R-type rd=3 rs1=1 rs2=2 f3=0, f7b5=0 then f7b5=1, back-to-back -> addr 0 0x002081B3, addr 1 0x402081B3 on consecutive cycles.
- SW rs2=6 rs1=2 imm=12, then B_TYPE rs1=1 rs2=2 f3=0 imm=-4 with i_last=1 -> 0x00612623, 0xFE208EE3, then o_done=1, o_busy=0.
- B_TYPE imm=3 -> no write, o_error=1, o_ready=0; i_start -> o_error=0, address restarts at 0.
- Stream IMEM_DEPTH valid bundles with no i_last -> 64 writes at 0..63, o_done after the last, o_ready=0 thereafter; with INSTR_ENCODER_CHECKSUM_EN, o_checksum equals the model XOR.
- Drop i_arst_n in the cycle after a handshake -> no write strobe, all outputs 0, state IDLE.

Source files
------------

// File: rtl/pa_riscv_pkg.sv
// Shared RISC-V field definitions for the program-loader encoder.
//   op_class_t   : instruction class carried on the encoder input stream
//   OPC_*        : 7-bit base opcodes for the supported word formats
//   FUNCT3_LW_SW : funct3 used for word-sized loads and stores
//   ST_*         : encoder session FSM state codes
package pa_riscv;

    typedef enum logic [1:0] {
        OP_LW      = 2'd0,
        OP_SW      = 2'd1,
        OP_R_ALU   = 2'd2,
        OP_B       = 2'd3
    } op_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R_ALU  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] FUNCT3_LW_SW = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_word_pack: combinational packer from decoded fields to one RV32I word.
// Ports:
//   op_class     in  2   instruction class (pa_riscv::op_class_t encoding)
//   rd/rs1/rs2   in  5   register indices
//   funct3       in  3   funct3 for R-type and B-type
//   funct7bit5   in  1   R-type bit 30 (SUB/SRA select)
//   imm          in  13  signed byte offset
//   word         out 32  packed instruction
//   illegal      out 1   bundle cannot be encoded
import pa_riscv::*;

module instr_word_pack (
    input  logic [1:0]  op_class,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7bit5,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Load/store offsets are 12-bit signed; the 13-bit input only fits when
    // its top two bits agree (no lost sign information).
    logic imm12_overflow;
    assign imm12_overflow = imm[12] ^ imm[11];

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (op_class)
            OP_LW: begin
                word    = {imm[11:0], rs1, FUNCT3_LW_SW, rd, OPC_LOAD};
                illegal = imm12_overflow;
            end
            OP_SW: begin
                word    = {imm[11:5], rs2, rs1, FUNCT3_LW_SW, imm[4:0], OPC_STORE};
                illegal = imm12_overflow;
            end
            OP_R_ALU: begin
                word    = {1'b0, funct7bit5, 5'b00000, rs2, rs1, funct3, rd, OPC_R_ALU};
            end
            OP_B: begin
                // Branch targets are halfword aligned; bit 0 is not encodable.
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                illegal = imm[0];
            end
            default: begin
                word    = 32'd0;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: program loader that packs decoded instruction fields into
// RV32I words and writes them sequentially into instruction memory.
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN adds o_checksum, the XOR
// of every word written in the current session.
// Ports:
//   i_clk, i_arst_n          clock, async active-low reset
//   i_start                  begin/restart a session at word address 0
//   i_valid / o_ready        field-bundle handshake
//   i_opClass, i_rd, i_rs1, i_rs2, i_funct3, i_funct7bit5, i_imm, i_last
//                            bundle fields
//   o_imemWriteEn/Addr/WriteData  one-cycle write strobe, 1 cycle after accept
//   o_busy, o_done, o_error  session status (o_done/o_error held until i_start)
//
// state   | meaning
// IDLE    | after reset, waiting for the first i_start
// LOAD    | accepting bundles
// DONE    | program complete (i_last or memory full); final write may be in flight
// ERR     | an illegal bundle was rejected
import pa_riscv::*;

module instr_encoder #(
    parameter  int IMEM_DEPTH = 64,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_opClass,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7bit5,
    input  logic [12:0]       i_imm,
    input  logic              i_last,
    output logic              o_imemWriteEn,
    output logic [ADDR_W-1:0] o_imemAddr,
    output logic [31:0]       o_imemWriteData,
`ifdef INSTR_ENCODER_CHECKSUM_EN
    output logic [31:0]       o_checksum,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              wr_last_q;
    logic              done_q;
    logic              error_q;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        pend_full;
    logic        ready;
    logic        accept;
    logic        is_last;

    instr_word_pack u_pack (
        .op_class   (i_opClass),
        .rd         (i_rd),
        .rs1        (i_rs1),
        .rs2        (i_rs2),
        .funct3     (i_funct3),
        .funct7bit5 (i_funct7bit5),
        .imm        (i_imm),
        .word       (packed_word),
        .illegal    (packed_illegal)
    );

    assign pend_full = wr_en_q && (wr_addr_q == LAST_ADDR);
    assign ready     = (state == ST_LOAD) && !pend_full;
    // i_start takes priority; a bundle presented in the same cycle is discarded.
    assign accept    = i_valid && ready && !i_start;
    assign is_last   = i_last || (addr_cnt == LAST_ADDR);

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            checksum_q <= 32'd0;
        end else if (i_start) begin
            checksum_q <= 32'd0;
        end else if (accept && !packed_illegal) begin
            checksum_q <= checksum_q ^ packed_word;
        end
    end

    assign o_checksum = checksum_q;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= ST_IDLE;
            addr_cnt  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
            wr_last_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;

            // o_done follows the final write strobe by one cycle.
            if (wr_en_q && wr_last_q) begin
                done_q <= 1'b1;
            end

            if (i_start) begin
                state    <= ST_LOAD;
                addr_cnt <= '0;
                done_q   <= 1'b0;
                error_q  <= 1'b0;
            end else if (accept) begin
                if (packed_illegal) begin
                    state   <= ST_ERR;
                    error_q <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_cnt;
                    wr_data_q <= packed_word;
                    wr_last_q <= is_last;
                    addr_cnt  <= addr_cnt + ADDR_W'(1);
                    // Leaving LOAD at accept time blocks further bundles while
                    // the final write is still in flight.
                    if (is_last) begin
                        state <= ST_DONE;
                    end
                end
            end
        end
    end

    assign o_ready         = ready;
    assign o_imemWriteEn   = wr_en_q;
    assign o_imemAddr      = wr_addr_q;
    assign o_imemWriteData = wr_data_q;
    assign o_busy          = (state == ST_LOAD) || wr_en_q;
    assign o_done          = done_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int DEPTH = 64;
    localparam logic [1:0] C_LW = 2'd0;
    localparam logic [1:0] C_SW = 2'd1;
    localparam logic [1:0] C_R  = 2'd2;
    localparam logic [1:0] C_B  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [1:0]  op_class = 2'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        f7b5 = 1'b0;
    logic [12:0] imm = 13'd0;
    logic        last = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_encoder #(.IMEM_DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_arst_n        (rst_n),
        .i_start         (start),
        .i_valid         (valid),
        .o_ready         (ready),
        .i_opClass       (op_class),
        .i_rd            (rd),
        .i_rs1           (rs1),
        .i_rs2           (rs2),
        .i_funct3        (funct3),
        .i_funct7bit5    (f7b5),
        .i_imm           (imm),
        .i_last          (last),
        .o_imemWriteEn   (wr_en),
        .o_imemAddr      (wr_addr),
        .o_imemWriteData (wr_data),
`ifdef INSTR_ENCODER_CHECKSUM_EN
        .o_checksum      (checksum),
`endif
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [5:0]  exp_addr = 6'd0;
    logic [31:0] model_xor = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", {26'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", {26'd0, wr_addr}, {26'd0, e.addr});
                chk("write_data", wr_data, e.data);
                chk("write_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 6'd0;
        model_xor = 32'd0;
    endtask

    // Presents one bundle at a negedge and waits (bounded) for acceptance.
    task automatic send(input logic [1:0] oc, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                        input logic [4:0] f_rs2, input logic [2:0] f_f3, input logic f_f7,
                        input logic [12:0] f_imm, input logic f_last,
                        input logic push, input logic [31:0] exp_data);
        int n;
        @(negedge clk);
        valid = 1'b1; op_class = oc; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        funct3 = f_f3; f7b5 = f_f7; imm = f_imm; last = f_last;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, ready}, 32'd1);
            valid = 1'b0;
            return;
        end
        if (push) begin
            sb.push_back('{addr: exp_addr, data: exp_data, cyc: cyc + 1});
            exp_addr = exp_addr + 6'd1;
            model_xor = model_xor ^ exp_data;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        last = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_addr", {26'd0, wr_addr}, 32'd0);
        rst_n = 1'b1;

        // LW rd=5 rs1=2 imm=8
        pulse_start();
        chk("load_ready", {31'd0, ready}, 32'd1);
        chk("load_busy", {31'd0, busy}, 32'd1);
        send(C_LW, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8, 1'b0, 1'b1, 32'h0081_2283);
        idle();

        // Back-to-back ADD / SUB
        pulse_start();
        send(C_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b0, 1'b1, 32'h0020_81B3);
        send(C_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 1'b0, 1'b1, 32'h4020_81B3);
        idle();

        // SW then BEQ -4 with last
        pulse_start();
        send(C_SW, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 13'd12, 1'b0, 1'b1, 32'h0061_2623);
        send(C_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FFC, 1'b1, 1'b1, 32'hFE20_8EE3);
        idle();
        chk("last_ready_low", {31'd0, ready}, 32'd0);
        chk("last_busy_pending", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("last_done", {31'd0, done}, 32'd1);
        chk("last_busy_clear", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("done_held", {31'd0, done}, 32'd1);

        // Illegal B_TYPE imm=3, then recovery
        pulse_start();
        chk("restart_done_clear", {31'd0, done}, 32'd0);
        send(C_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd3, 1'b0, 1'b0, 32'd0);
        idle();
        chk("illegal_error", {31'd0, error}, 32'd1);
        chk("illegal_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("error_sticky", {31'd0, error}, 32'd1);
        pulse_start();
        chk("error_cleared", {31'd0, error}, 32'd0);
        send(C_LW, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8, 1'b0, 1'b1, 32'h0081_2283);
        // Load offset out of 12-bit range is also illegal
        send(C_LW, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'd2048, 1'b0, 1'b0, 32'd0);
        idle();
        chk("lw_range_error", {31'd0, error}, 32'd1);

        // Stream DEPTH bundles without last
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] e;
            e = (32'(i) * 32'd4 << 20) | (32'd1 << 15) | (32'd2 << 12) | ((32'(i) & 32'h1F) << 7) | 32'd3;
            send(C_LW, 5'(i), 5'd1, 5'd0, 3'd0, 1'b0, 13'(i * 4), 1'b0, 1'b1, e);
        end
        @(negedge clk);
        chk("full_ready_low", {31'd0, ready}, 32'd0);
        chk("full_done_not_yet", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_busy_clear", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("full_ready_stays_low", {31'd0, ready}, 32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("checksum", checksum, model_xor);
`endif
        valid = 1'b0;

        // Reset in the cycle after a handshake drops the write
        pulse_start();
        send(C_LW, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8, 1'b0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd0);
        chk("arst_data", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
